// File: rtl/axi_sub_mem.sv
// Single-beat AXI4 subordinate backed by a 2^MEM_AW-word on-chip memory.
// Write (AW/W -> B) and read (AR -> R) paths are independent, one transaction in flight each.
module axi_sub_mem #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MEM_AW = 10
) (
  input  logic              aCLK,
  input  logic              ARESETn,
  // Write address channel
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  // Write data channel
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  // Write response channel
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  // Read address channel
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  // Read data channel
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY
);

  localparam int unsigned Depth    = 1 << MEM_AW;
  localparam logic [1:0]  RespOkay = 2'b00;
  localparam logic [1:0]  RespSlv  = 2'b10;

  typedef enum logic [1:0] {WIdle, WCommit, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RFetch, RResp} r_state_e;

  logic [DATA_W-1:0] mem_q [Depth];

  // Write path state
  w_state_e          w_state_q, w_state_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [ADDR_W-1:0] aw_q, aw_d;
  logic [DATA_W-1:0] w_q, w_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              mem_we;

  // Read path state
  r_state_e          r_state_q, r_state_d;
  logic [ADDR_W-1:0] ar_q, ar_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic aw_hs, w_hs, ar_hs;
  logic aw_in_range, ar_in_range;

  assign aw_in_range = (aw_q[ADDR_W-1:MEM_AW] == '0);
  assign ar_in_range = (ar_q[ADDR_W-1:MEM_AW] == '0);

  assign AWREADY = (w_state_q == WIdle) && !aw_held_q;
  assign WREADY  = (w_state_q == WIdle) && !w_held_q;
  assign ARREADY = (r_state_q == RIdle);

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;

  assign BVALID = bvalid_q;
  assign BRESP  = bresp_q;
  assign RVALID = rvalid_q;
  assign RRESP  = rresp_q;
  assign RDATA  = rdata_q;

  // Write FSM next-state
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_d      = aw_q;
    w_d       = w_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_d      = AWADDR;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          w_d      = WDATA;
        end
        // Leave idle on the edge that captures the second half of the pair.
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          w_state_d = WCommit;
        end
      end
      WCommit: begin
        mem_we    = aw_in_range;
        bresp_d   = aw_in_range ? RespOkay : RespSlv;
        bvalid_d  = 1'b1;
        w_state_d = WResp;
      end
      WResp: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Read FSM next-state
  always_comb begin
    r_state_d = r_state_q;
    ar_d      = ar_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          ar_d      = ARADDR;
          r_state_d = RFetch;
        end
      end
      RFetch: begin
        // Samples mem_q before any same-edge write lands, so a collision sees the old word.
        rdata_d   = ar_in_range ? mem_q[ar_q[MEM_AW-1:0]] : '0;
        rresp_d   = ar_in_range ? RespOkay : RespSlv;
        rvalid_d  = 1'b1;
        r_state_d = RResp;
      end
      RResp: begin
        if (RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge aCLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= WIdle;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_q      <= '0;
      w_q       <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      r_state_q <= RIdle;
      ar_q      <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RespOkay;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_q      <= aw_d;
      w_q       <= w_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      ar_q      <= ar_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage is deliberately not reset; mem_we is only high in WCommit, which reset leaves.
  always_ff @(posedge aCLK) begin
    if (mem_we) begin
      mem_q[aw_q[MEM_AW-1:0]] <= w_q;
    end
  end

endmodule
